i2c_slave_ctrl: RTL and testbench

//   Moore FSM that sequences the I2C slave (slave-transmitter only): consumes start/stop/address

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_slave_ctrl.sv | 85 ++++++++
 tb/tb_i2c_slave_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: controller state encoding, SDA output modes and the slave address.
package i2c_pkg;

  localparam logic [6:0] SLAVE_ADDR = 7'b1011001;

  localparam logic [1:0] SDA_IDLE = 2'b00;
  localparam logic [1:0] SDA_ACK  = 2'b01;
  localparam logic [1:0] SDA_NACK = 2'b10;
  localparam logic [1:0] SDA_TX   = 2'b11;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR_RX   = 4'd1,
    ADDR_CHK  = 4'd2,
    ACK_WAIT  = 4'd3,
    NACK_WAIT = 4'd4,
    ACK_DRV   = 4'd5,
    NACK_DRV  = 4'd6,
    LOAD      = 4'd7,
    TX        = 4'd8,
    POP       = 4'd9,
    MACK_WAIT = 4'd10,
    MACK_OK   = 4'd11
  } ctrl_state_t;

endpackage

// File: rtl/i2c_slave_ctrl.sv
// Moore sequencer for a slave-transmitter-only I2C target: turns decode/timer events into
// shift enables, TX FIFO load/pop strobes and the SDA output mode.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int BYTE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start_found,
  input  logic                  stop_found,
  input  logic                  address_match,
  input  logic                  rw_mode,
  input  logic                  byte_received,
  input  logic                  ack_prepare,
  input  logic                  check_ack,
  input  logic                  ack_done,
  input  logic                  sda_in,
  input  logic                  tx_fifo_empty,
  output logic                  rx_enable,
  output logic                  tx_enable,
  output logic                  load_data,
  output logic                  read_enable,
  output logic [1:0]            sda_mode,
  output logic                  busy,
  output logic [BYTE_CNT_W-1:0] byte_count
);

  ctrl_state_t state, next_state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_found) next_state = ADDR_RX;
      ADDR_RX:   if (byte_received) next_state = ADDR_CHK;
      ADDR_CHK:  next_state = (address_match && rw_mode && !tx_fifo_empty) ? ACK_WAIT : NACK_WAIT;
      ACK_WAIT:  if (ack_prepare) next_state = ACK_DRV;
      NACK_WAIT: if (ack_prepare) next_state = NACK_DRV;
      ACK_DRV:   if (ack_done) next_state = LOAD;
      NACK_DRV:  if (ack_done) next_state = IDLE;
      LOAD:      next_state = TX;
      TX:        if (ack_prepare) next_state = POP;
      POP:       next_state = MACK_WAIT;
      MACK_WAIT: if (check_ack) next_state = sda_in ? IDLE : MACK_OK;
      MACK_OK:   if (ack_done) next_state = tx_fifo_empty ? IDLE : LOAD;
      default:   next_state = IDLE;
    endcase
    // STOP beats everything; a repeated START restarts address reception.
    if (stop_found) next_state = IDLE;
    else if (start_found && state != IDLE) next_state = ADDR_RX;
  end

  always_comb begin
    rx_enable   = 1'b0;
    tx_enable   = 1'b0;
    load_data   = 1'b0;
    read_enable = 1'b0;
    sda_mode    = SDA_IDLE;
    busy        = (state != IDLE);
    case (state)
      ADDR_RX:  rx_enable = 1'b1;
      ACK_DRV:  sda_mode = SDA_ACK;
      NACK_DRV: sda_mode = SDA_NACK;
      LOAD:     load_data = 1'b1;
      TX: begin
        tx_enable = 1'b1;
        sda_mode  = SDA_TX;
      end
      POP:      read_enable = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                  byte_count <= '0;
    else if (start_found)                        byte_count <= '0;
    else if (state == POP && byte_count != '1)   byte_count <= byte_count + 1'b1;
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: walks address, ACK/NACK, multi-byte read, override and reset cases.
module tb_i2c_slave_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start_found, stop_found, address_match, rw_mode, byte_received;
  logic       ack_prepare, check_ack, ack_done, sda_in, tx_fifo_empty;
  logic       rx_enable, tx_enable, load_data, read_enable, busy;
  logic [1:0] sda_mode;
  logic [7:0] byte_count;

  int tests_run = 0;
  int tests_failed = 0;

  i2c_slave_ctrl #(.BYTE_CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .start_found(start_found), .stop_found(stop_found),
    .address_match(address_match), .rw_mode(rw_mode),
    .byte_received(byte_received), .ack_prepare(ack_prepare),
    .check_ack(check_ack), .ack_done(ack_done),
    .sda_in(sda_in), .tx_fifo_empty(tx_fifo_empty),
    .rx_enable(rx_enable), .tx_enable(tx_enable),
    .load_data(load_data), .read_enable(read_enable),
    .sda_mode(sda_mode), .busy(busy), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change #1 after the edge so they are stable at the next one.
  task automatic tick();
    @(posedge clk);
    #1;
    start_found   = 1'b0;
    stop_found    = 1'b0;
    byte_received = 1'b0;
    ack_prepare   = 1'b0;
    check_ack     = 1'b0;
    ack_done      = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // START plus address byte; returns with the FSM in ADDR_CHK.
  task automatic send_addr(input logic match, input logic rw, input logic empty);
    start_found = 1'b1;
    tick();
    address_match = match;
    rw_mode       = rw;
    tx_fifo_empty = empty;
    byte_received = 1'b1;
    tick();
  endtask

  // Accepted read address through to the first TX state.
  task automatic go_tx();
    send_addr(1'b1, 1'b1, 1'b0);
    tick();
    ack_prepare = 1'b1; tick();
    ack_done = 1'b1;    tick();
    tick();
  endtask

  initial begin
    n_rst = 1'b0;
    start_found = 0; stop_found = 0; address_match = 0; rw_mode = 0; byte_received = 0;
    ack_prepare = 0; check_ack = 0; ack_done = 0; sda_in = 1; tx_fifo_empty = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_sda", {6'd0, sda_mode}, 8'd0);
    chk("rst_outs", {4'd0, rx_enable, tx_enable, load_data, read_enable}, 8'd0);
    chk("rst_cnt", byte_count, 8'd0);
    n_rst = 1'b1;
    tick();

    // 1: addr 0xB3 accepted, ACK driven, one load, then TX
    start_found = 1'b1; tick();
    chk("t1_rx_en", {7'd0, rx_enable}, 8'd1);
    chk("t1_busy", {7'd0, busy}, 8'd1);
    address_match = 1; rw_mode = 1; tx_fifo_empty = 0; byte_received = 1; tick();
    chk("t1_chk_rx_off", {7'd0, rx_enable}, 8'd0);
    tick();
    chk("t1_wait_sda", {6'd0, sda_mode}, 8'd0);
    ack_prepare = 1; tick();
    chk("t1_ack_sda", {6'd0, sda_mode}, 8'd1);
    tick();
    chk("t1_ack_hold", {6'd0, sda_mode}, 8'd1);
    ack_done = 1; tick();
    chk("t1_load", {7'd0, load_data}, 8'd1);
    chk("t1_load_sda", {6'd0, sda_mode}, 8'd0);
    tick();
    chk("t1_load_1cyc", {7'd0, load_data}, 8'd0);
    chk("t1_tx_en", {7'd0, tx_enable}, 8'd1);
    chk("t1_tx_sda", {6'd0, sda_mode}, 8'd3);

    // 3: two bytes, master ACK then NACK
    ack_prepare = 1; tick();
    chk("t3_pop1", {7'd0, read_enable}, 8'd1);
    chk("t3_cnt_pre", byte_count, 8'd0);
    tick();
    chk("t3_pop1_1cyc", {7'd0, read_enable}, 8'd0);
    chk("t3_cnt1", byte_count, 8'd1);
    chk("t3_mack_sda", {6'd0, sda_mode}, 8'd0);
    sda_in = 0; check_ack = 1; tick();
    ack_done = 1; tick();
    chk("t3_load2", {7'd0, load_data}, 8'd1);
    tick();
    ack_prepare = 1; tick();
    chk("t3_pop2", {7'd0, read_enable}, 8'd1);
    tick();
    chk("t3_cnt2", byte_count, 8'd2);
    sda_in = 1; check_ack = 1; tick();
    chk("t3_idle", {7'd0, busy}, 8'd0);
    chk("t3_cnt_held", byte_count, 8'd2);

    // 2: write request (0xB2) and address mismatch (0xA3) both NACK
    send_addr(1'b1, 1'b0, 1'b0);
    chk("t2_cnt_clr", byte_count, 8'd0);
    tick();
    ack_prepare = 1; tick();
    chk("t2w_nack", {6'd0, sda_mode}, 8'd2);
    ack_done = 1; tick();
    chk("t2w_idle", {7'd0, busy}, 8'd0);
    chk("t2w_no_load", {6'd0, load_data, read_enable}, 8'd0);
    send_addr(1'b0, 1'b1, 1'b0);
    tick();
    ack_prepare = 1; tick();
    chk("t2m_nack", {6'd0, sda_mode}, 8'd2);
    ack_done = 1; tick();
    chk("t2m_idle", {7'd0, busy}, 8'd0);

    // 4: empty FIFO at address NACKs; FIFO empty at master ACK ends the transfer
    send_addr(1'b1, 1'b1, 1'b1);
    tick();
    ack_prepare = 1; tick();
    chk("t4_nack", {6'd0, sda_mode}, 8'd2);
    ack_done = 1; tick();
    chk("t4_nack_idle", {7'd0, busy}, 8'd0);
    go_tx();
    ack_prepare = 1; tick();
    tick();
    tx_fifo_empty = 1; sda_in = 0; check_ack = 1; tick();
    ack_done = 1; tick();
    chk("t4_empty_idle", {7'd0, busy}, 8'd0);
    chk("t4_no_load", {7'd0, load_data}, 8'd0);
    chk("t4_cnt", byte_count, 8'd1);
    tx_fifo_empty = 0;

    // 5: STOP in TX; repeated START in MACK_WAIT; simultaneous START+STOP
    go_tx();
    stop_found = 1; tick();
    chk("t5_stop_busy", {7'd0, busy}, 8'd0);
    chk("t5_stop_outs", {2'd0, sda_mode, rx_enable, tx_enable, load_data, read_enable}, 8'd0);
    go_tx();
    ack_prepare = 1; tick();
    tick();
    chk("t5_cnt1", byte_count, 8'd1);
    start_found = 1; tick();
    chk("t5_rs_rx", {7'd0, rx_enable}, 8'd1);
    chk("t5_rs_cnt", byte_count, 8'd0);
    start_found = 1; stop_found = 1; tick();
    chk("t5_both_idle", {7'd0, busy}, 8'd0);

    // 6: asynchronous reset mid-TX with a nonzero byte count
    go_tx();
    ack_prepare = 1; tick();
    tick();
    sda_in = 0; check_ack = 1; tick();
    ack_done = 1; tick();
    tick();
    chk("t6_pre_tx", {6'd0, sda_mode}, 8'd3);
    chk("t6_pre_cnt", byte_count, 8'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_sda", {6'd0, sda_mode}, 8'd0);
    chk("t6_tx_en", {7'd0, tx_enable}, 8'd0);
    chk("t6_busy", {7'd0, busy}, 8'd0);
    chk("t6_cnt", byte_count, 8'd0);
    #1 n_rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
